// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the scoreboarded register file.
//   REGFILE_DATA_W / REGFILE_ADDR_W : default register width / address width
//   reg_addr_t                      : register address at the default width
//   REG_ZERO                        : address of the hardwired-zero register
package regfile_pkg;
    localparam int unsigned REGFILE_DATA_W = 32;
    localparam int unsigned REGFILE_ADDR_W = 5;

    typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, reserve arbitration and busy counter.
// Ports:
//   clock, ctrl_reset    : clock, asynchronous active-low reset
//   wr_en, wr_addr       : writeback strobe/address (clears busy)
//   res_en, res_addr     : reserve request/address (sets busy)
//   reserve_stall        : reserve refused this cycle (combinational)
//   busy                 : registered busy bit vector, bit 0 always 0
//   busy_count           : popcount of busy
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = REGFILE_ADDR_W
) (
    input  logic                   clock,
    input  logic                   ctrl_reset,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic                   res_en,
    input  logic [ADDR_W-1:0]      res_addr,
    output logic                   reserve_stall,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [ADDR_W:0]        busy_count
);
    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  count_q, count_d;
    logic             wr_hit, res_ok, inc, dec;

    always_comb begin
        wr_hit        = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
        // A same-cycle write to the reserved register frees it, so no stall.
        reserve_stall = res_en && busy_q[res_addr] && !(wr_hit && (wr_addr == res_addr));
        res_ok        = res_en && !reserve_stall && (res_addr != ADDR_W'(REG_ZERO));

        busy_d = busy_q;
        if (wr_hit) busy_d[wr_addr] = 1'b0;
        // Reserve applied after the write so it wins on a same-register collision.
        if (res_ok) busy_d[res_addr] = 1'b1;

        // Count tracks the net bit change: a write+reserve to one busy
        // register leaves the bit set and must not decrement.
        inc = res_ok && !busy_q[res_addr];
        dec = wr_hit && busy_q[wr_addr] && !(res_ok && (res_addr == wr_addr));

        count_d = count_q;
        if (inc && !dec)      count_d = count_q + (ADDR_W+1)'(1);
        else if (dec && !inc) count_d = count_q - (ADDR_W+1)'(1);
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy       = busy_q;
    assign busy_count = count_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with one write port, two combinational read ports,
// hardwired-zero register 0, per-register scoreboard and a debug tap.
// Ports:
//   clock, ctrl_reset                      : clock, asynchronous active-low reset
//   ctrl_writeEnable/WriteReg, data_writeReg : write port
//   ctrl_readRegA/B -> data_readRegA/B     : combinational read data
//   ready_readRegA/B                       : addressed register not reserved
//   ctrl_reserveEnable/ctrl_reserveReg     : reserve request
//   reserve_stall                          : reserve refused this cycle
//   busy_count                             : number of busy registers
//   data_tap                               : stored value of register TAP_REG
// Option: define REGFILE_BYPASS_EN to forward same-cycle write data/ready to reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = REGFILE_DATA_W,
    parameter int unsigned ADDR_W  = REGFILE_ADDR_W,
    parameter int unsigned TAP_REG = 1
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic              ready_readRegA,
    output logic              ready_readRegB,
    input  logic              ctrl_reserveEnable,
    input  logic [ADDR_W-1:0] ctrl_reserveReg,
    output logic              reserve_stall,
    output logic [ADDR_W:0]   busy_count,
    output logic [DATA_W-1:0] data_tap
);
    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_hit;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .wr_en         (ctrl_writeEnable),
        .wr_addr       (ctrl_writeReg),
        .res_en        (ctrl_reserveEnable),
        .res_addr      (ctrl_reserveReg),
        .reserve_stall (reserve_stall),
        .busy          (busy),
        .busy_count    (busy_count)
    );

    assign wr_hit = ctrl_writeEnable && (ctrl_writeReg != ADDR_W'(REG_ZERO));

    // Register 0 is never written and resets to 0, so it always reads 0.
    always_comb begin
        regs_d = regs_q;
        if (wr_hit) regs_d[ctrl_writeReg] = data_writeReg;
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) regs_q <= '{default: '0};
        else             regs_q <= regs_d;
    end

    always_comb begin
        data_readRegA  = regs_q[ctrl_readRegA];
        data_readRegB  = regs_q[ctrl_readRegB];
        ready_readRegA = ~busy[ctrl_readRegA];
        ready_readRegB = ~busy[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (ctrl_readRegA == ctrl_writeReg)) begin
            data_readRegA  = data_writeReg;
            ready_readRegA = 1'b1;
        end
        if (wr_hit && (ctrl_readRegB == ctrl_writeReg)) begin
            data_readRegB  = data_writeReg;
            ready_readRegB = 1'b1;
        end
`endif
    end

    assign data_tap = regs_q[TAP_REG];
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clock = 1'b0;
    logic              ctrl_reset;
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic [ADDR_W-1:0] ctrl_readRegA;
    logic [ADDR_W-1:0] ctrl_readRegB;
    logic [DATA_W-1:0] data_readRegA;
    logic [DATA_W-1:0] data_readRegB;
    logic              ready_readRegA;
    logic              ready_readRegB;
    logic              ctrl_reserveEnable;
    logic [ADDR_W-1:0] ctrl_reserveReg;
    logic              reserve_stall;
    logic [ADDR_W:0]   busy_count;
    logic [DATA_W-1:0] data_tap;

    int n_cmp = 0;
    int n_err = 0;

    regfile_sb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TAP_REG (1)
    ) dut (
        .clock              (clock),
        .ctrl_reset         (ctrl_reset),
        .ctrl_writeEnable   (ctrl_writeEnable),
        .ctrl_writeReg      (ctrl_writeReg),
        .data_writeReg      (data_writeReg),
        .ctrl_readRegA      (ctrl_readRegA),
        .ctrl_readRegB      (ctrl_readRegB),
        .data_readRegA      (data_readRegA),
        .data_readRegB      (data_readRegB),
        .ready_readRegA     (ready_readRegA),
        .ready_readRegB     (ready_readRegB),
        .ctrl_reserveEnable (ctrl_reserveEnable),
        .ctrl_reserveReg    (ctrl_reserveReg),
        .reserve_stall      (reserve_stall),
        .busy_count         (busy_count),
        .data_tap           (data_tap)
    );

    always #5 clock = ~clock;

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ctrl_writeEnable   = 1'b0;
        ctrl_writeReg      = '0;
        data_writeReg      = '0;
        ctrl_reserveEnable = 1'b0;
        ctrl_reserveReg    = '0;
    endtask

    task automatic test_reset();
        ctrl_reset    = 1'b0;
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd0;
        idle();
        tick();
        tick();
        n_cmp++; if (busy_count !== 6'd0) begin n_err++; $display("FAIL reset_busy_count got=%0d exp=0", busy_count); end
        n_cmp++; if (data_tap !== 32'h0) begin n_err++; $display("FAIL reset_tap got=%h exp=0", data_tap); end
        n_cmp++; if (data_readRegA !== 32'h0 || ready_readRegA !== 1'b1) begin
            n_err++; $display("FAIL reset_readA got=%h/%b exp=0/1", data_readRegA, ready_readRegA); end
        ctrl_reset = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
        ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd0;
        tick();
        idle();
        #1;
        n_cmp++; if (data_readRegA !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_readA got=%h exp=deadbeef", data_readRegA); end
        n_cmp++; if (ready_readRegA !== 1'b1) begin n_err++; $display("FAIL wr_readyA got=%b exp=1", ready_readRegA); end
        n_cmp++; if (data_readRegB !== 32'h0) begin n_err++; $display("FAIL wr_readB_zero got=%h exp=0", data_readRegB); end
        n_cmp++; if (data_tap !== 32'h0) begin n_err++; $display("FAIL wr_tap_untouched got=%h exp=0", data_tap); end
        // Register 1 feeds the tap.
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd1; data_writeReg = 32'h0BADF00D;
        tick();
        idle();
        #1;
        n_cmp++; if (data_tap !== 32'h0BADF00D) begin n_err++; $display("FAIL tap_reg1 got=%h exp=0badf00d", data_tap); end
    endtask

    task automatic test_reg_zero();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'h1234;
        ctrl_readRegA = 5'd0;
        #1;
        n_cmp++; if (data_readRegA !== 32'h0) begin n_err++; $display("FAIL zero_no_bypass got=%h exp=0", data_readRegA); end
        tick();
        idle();
        #1;
        n_cmp++; if (data_readRegA !== 32'h0 || ready_readRegA !== 1'b1) begin
            n_err++; $display("FAIL zero_read got=%h/%b exp=0/1", data_readRegA, ready_readRegA); end
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd0;
        #1;
        n_cmp++; if (reserve_stall !== 1'b0) begin n_err++; $display("FAIL zero_reserve_stall got=%b exp=0", reserve_stall); end
        tick();
        idle();
        #1;
        n_cmp++; if (busy_count !== 6'd0 || ready_readRegA !== 1'b1) begin
            n_err++; $display("FAIL zero_reserve_count got=%0d/%b exp=0/1", busy_count, ready_readRegA); end
    endtask

    task automatic test_reserve();
        ctrl_readRegA = 5'd7;
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd7;
        #1;
        n_cmp++; if (reserve_stall !== 1'b0) begin n_err++; $display("FAIL res7_first_stall got=%b exp=0", reserve_stall); end
        n_cmp++; if (ready_readRegA !== 1'b1) begin n_err++; $display("FAIL res7_ready_same_cycle got=%b exp=1", ready_readRegA); end
        tick();
        #1;
        n_cmp++; if (ready_readRegA !== 1'b0 || busy_count !== 6'd1) begin
            n_err++; $display("FAIL res7_busy got=%b/%0d exp=0/1", ready_readRegA, busy_count); end
        // Still requesting reg 7: must now be refused.
        n_cmp++; if (reserve_stall !== 1'b1) begin n_err++; $display("FAIL res7_second_stall got=%b exp=1", reserve_stall); end
        tick();
        idle();
        #1;
        n_cmp++; if (busy_count !== 6'd1) begin n_err++; $display("FAIL res7_refused_count got=%0d exp=1", busy_count); end
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'hAA;
        tick();
        idle();
        #1;
        n_cmp++; if (ready_readRegA !== 1'b1 || data_readRegA !== 32'hAA || busy_count !== 6'd0) begin
            n_err++; $display("FAIL res7_writeback got=%b/%h/%0d exp=1/aa/0", ready_readRegA, data_readRegA, busy_count); end
    endtask

    task automatic test_same_cycle();
        ctrl_readRegA = 5'd9;
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd9;
        tick();
        idle();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h55;
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd9;
        #1;
        n_cmp++; if (reserve_stall !== 1'b0) begin n_err++; $display("FAIL same_stall got=%b exp=0", reserve_stall); end
`ifdef REGFILE_BYPASS_EN
        n_cmp++; if (ready_readRegA !== 1'b1) begin n_err++; $display("FAIL same_bypass_ready got=%b exp=1", ready_readRegA); end
`else
        n_cmp++; if (ready_readRegA !== 1'b0) begin n_err++; $display("FAIL same_ready_busy got=%b exp=0", ready_readRegA); end
`endif
        tick();
        idle();
        #1;
        n_cmp++; if (data_readRegA !== 32'h55 || ready_readRegA !== 1'b0 || busy_count !== 6'd1) begin
            n_err++; $display("FAIL same_result got=%h/%b/%0d exp=55/0/1", data_readRegA, ready_readRegA, busy_count); end
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h56;
        tick();
        idle();
        #1;
        n_cmp++; if (busy_count !== 6'd0 || ready_readRegA !== 1'b1) begin
            n_err++; $display("FAIL same_release got=%0d/%b exp=0/1", busy_count, ready_readRegA); end
    endtask

    task automatic test_bypass();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h1111;
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd4;
        tick();
        idle();
        // Write to a non-busy register while reading it.
        ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd4;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'hCAFE;
        #1;
`ifdef REGFILE_BYPASS_EN
        n_cmp++; if (data_readRegA !== 32'hCAFE) begin n_err++; $display("FAIL bypass_data got=%h exp=cafe", data_readRegA); end
`else
        n_cmp++; if (data_readRegA !== 32'h1111) begin n_err++; $display("FAIL nobypass_old got=%h exp=1111", data_readRegA); end
`endif
        tick();
        idle();
        #1;
        n_cmp++; if (data_readRegA !== 32'hCAFE) begin n_err++; $display("FAIL bypass_next got=%h exp=cafe", data_readRegA); end
        // Writeback of busy reg 4 with readB on it.
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'h4444;
        #1;
`ifdef REGFILE_BYPASS_EN
        n_cmp++; if (ready_readRegB !== 1'b1 || data_readRegB !== 32'h4444) begin
            n_err++; $display("FAIL bypassB got=%b/%h exp=1/4444", ready_readRegB, data_readRegB); end
`else
        n_cmp++; if (ready_readRegB !== 1'b0 || data_readRegB !== 32'h0) begin
            n_err++; $display("FAIL nobypassB got=%b/%h exp=0/0", ready_readRegB, data_readRegB); end
`endif
        tick();
        idle();
        #1;
        n_cmp++; if (ready_readRegB !== 1'b1 || data_readRegB !== 32'h4444 || busy_count !== 6'd0) begin
            n_err++; $display("FAIL wbB got=%b/%h/%0d exp=1/4444/0", ready_readRegB, data_readRegB, busy_count); end
    endtask

    task automatic test_fill_reset();
        int bad;
        for (int r = 1; r < 32; r++) begin
            ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'(r);
            tick();
        end
        idle();
        #1;
        n_cmp++; if (busy_count !== 6'd31) begin n_err++; $display("FAIL fill_count got=%0d exp=31", busy_count); end
        ctrl_readRegA = 5'd31;
        #1;
        n_cmp++; if (ready_readRegA !== 1'b0) begin n_err++; $display("FAIL fill_ready31 got=%b exp=0", ready_readRegA); end
        #1;
        ctrl_reset = 1'b0;
        #1;
        n_cmp++; if (busy_count !== 6'd0) begin n_err++; $display("FAIL rst_mid_count got=%0d exp=0", busy_count); end
        n_cmp++; if (data_tap !== 32'h0) begin n_err++; $display("FAIL rst_mid_tap got=%h exp=0", data_tap); end
        bad = 0;
        for (int r = 0; r < 32; r++) begin
            ctrl_readRegA = 5'(r);
            ctrl_readRegB = 5'(31 - r);
            #1;
            if (data_readRegA !== 32'h0 || ready_readRegA !== 1'b1 ||
                data_readRegB !== 32'h0 || ready_readRegB !== 1'b1) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rst_mid_all_regs bad_regs=%0d exp=0", bad); end
        ctrl_readRegA = 5'd5;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'h77;
        ctrl_reserveEnable = 1'b1; ctrl_reserveReg = 5'd6;
        tick();
        idle();
        #1;
        n_cmp++; if (data_readRegA !== 32'h0 || busy_count !== 6'd0) begin
            n_err++; $display("FAIL rst_held_write got=%h/%0d exp=0/0", data_readRegA, busy_count); end
        ctrl_reset = 1'b1;
        tick();
        #1;
        n_cmp++; if (data_readRegA !== 32'h0 || busy_count !== 6'd0) begin
            n_err++; $display("FAIL rst_release got=%h/%0d exp=0/0", data_readRegA, busy_count); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reg_zero();
        test_reserve();
        test_same_cycle();
        test_bypass();
        test_fill_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
